// File: rtl/sha256_round_engine.sv
// SHA-256 compression core: one round per clock over 64 rounds, then a
// final feed-forward addition of the base chaining value.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; h_in is latched on the start edge
// S_ROUND | one compression round per cycle, t = 0..63
// S_FINAL | h_out <= base + working registers, done pulses next cycle
module sha256_round_engine (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [255:0] h_in,
   input  logic [31:0]  wt_in,
   output logic [7:0]   t_out,
   output logic         busy,
   output logic         done,
   output logic [255:0] h_out
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_FINAL = 2'd2
   } state_t;

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   state_t state_q, state_d;
   logic [5:0]  t_q;
   logic [31:0] a, b, c, d, e, f, g, h;
   logic [7:0][31:0] hb;
   logic [31:0] s1, ch, t1, s0, maj, t2;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // next-state logic; start is only looked at in IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_ROUND;
         S_ROUND: if (t_q == 6'd63) state_d = S_FINAL;
         S_FINAL: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // status outputs decoded from state
   always_comb begin
      busy  = (state_q != S_IDLE);
      t_out = (state_q == S_ROUND) ? {2'b00, t_q} : 8'd0;
   end

   // round function for the current t
   always_comb begin
      s1  = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
      ch  = (e & f) ^ (~e & g);
      t1  = h + s1 + ch + K_TAB[t_q] + wt_in;
      s0  = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
      maj = (a & b) ^ (a & c) ^ (b & c);
      t2  = s0 + maj;
   end

   // datapath: latch, round update, feed-forward and done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         t_q   <= 6'd0;
         {a, b, c, d, e, f, g, h} <= 256'd0;
         hb    <= '0;
         h_out <= 256'd0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  hb  <= h_in;
                  {a, b, c, d, e, f, g, h} <= h_in;
                  t_q <= 6'd0;
               end
            end
            S_ROUND: begin
               h   <= g;
               g   <= f;
               f   <= e;
               e   <= d + t1;
               d   <= c;
               c   <= b;
               b   <= a;
               a   <= t1 + t2;
               // 6-bit counter wraps 63 -> 0 as we leave for FINAL
               t_q <= t_q + 6'd1;
            end
            S_FINAL: begin
               h_out <= {hb[7] + a, hb[6] + b, hb[5] + c, hb[4] + d,
                         hb[3] + e, hb[2] + f, hb[1] + g, hb[0] + h};
               done  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/sha256_round_engine.md
# sha256_round_engine

Sequential SHA-256 compression core: accepts a 256-bit chaining value and runs the 64 compression rounds, one per clock. It consumes one message-schedule word Wt per round from the schedule logic, which is indexed by this block's round counter, and outputs the updated chaining value. It sits directly downstream of the message-expansion stage and upstream of the block-level padding/control FSM.

## Interface

Parameters: none (SHA-256 fixed; K[0..63] hard-coded per FIPS 180-4).

Ports:

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin compression; sampled only in IDLE.
- `h_in`  in  256  input chaining value; H0 = `h_in[255:224]` … H7 = `h_in[31:0]`.
- `wt_in`  in  32  schedule word W[`t_out`]; must be valid combinationally in the same cycle as `t_out`.
- `t_out`  out  8  current round index 0..63; 0 outside ROUND.
- `busy`  out  1  high in ROUND and FINAL.
- `done`  out  1  one-cycle pulse when `h_out` is updated.
- `h_out`  out  256  result chaining value; same word order as `h_in`; holds until the next `done`.

## Operation

- State machine: IDLE → ROUND → FINAL → IDLE.
- **IDLE**
  - On `start`=1: latch `h_in` into base registers H0..H7 and working registers a..h.
  - Set t=0; go to ROUND.
  - Otherwise hold all state.
- **ROUND**, every cycle, arithmetic mod 2^32:
  - S1 = ror(e,6)^ror(e,11)^ror(e,25)
  - ch = (e&f)^(~e&g)
  - T1 = h+S1+ch+K[t]+`wt_in`
  - S0 = ror(a,2)^ror(a,13)^ror(a,22)
  - maj = (a&b)^(a&c)^(b&c)
  - T2 = S0+maj
  - Update: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - Increment t after each round. After the round with t=63, go to FINAL and set t=0.
- **FINAL**
  - `h_out` word i ← Hi + working word i (mod 2^32; a pairs with H0 … h with H7).
  - Assert `done` for one cycle; go to IDLE.
- `start` outside IDLE is ignored; no queuing.
- K table is a 64-entry constant ROM indexed by t.
- Internal adders are 32-bit wraparound; no carry out.

## Timing

- Reset values: `busy`=0, `done`=0, `t_out`=0, `h_out`=0, state IDLE, working and base registers 0.
- Let E0 be the edge that samples `start`=1 in IDLE:
  - Rounds t=0..63 execute at edges E1..E64.
  - `t_out`=k during the cycle between E(k) and E(k+1).
  - The FINAL update occurs at E65.
  - `done`=1 and the new `h_out` are visible in the cycle after E65.
  - Total latency: 65 cycles from the start edge to `done`.
- `busy` rises after E0 and falls after E65, together with the `done` rise.
- Back-to-back operation: `start` high in the `done` cycle is sampled at E66 and begins a new compression. Sustained throughput is 1 block per 66 cycles.
- `start` held permanently high restarts immediately after every `done`.
- `h_in` is sampled only at E0; later changes have no effect.
- `wt_in` is sampled only in ROUND; its value in IDLE and FINAL is don't-care.
- `reset` mid-operation (ROUND or FINAL) returns to IDLE on that edge:
  - no `done`;
  - `h_out` cleared to 0;
  - `start` in the same cycle as `reset` is ignored.

## Test plan

- **Reset check:** assert `reset` 2 cycles. Required: `busy`=0, `done`=0, `t_out`=0, `h_out`=0. Hold `start`=0 for 10 cycles: outputs unchanged.
- **"abc" single block:** `h_in` = IV (6a09e667 … 5be0cd19); bench drives W[t] from a reference schedule. Required:
  - `h_out` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad;
  - `done` exactly 65 cycles after the start edge, one cycle wide;
  - `t_out` steps 0..63 over consecutive cycles.
- **Empty message:** padded block 80000000, 0×15 words, IV input. Required: `h_out` = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- **Back-to-back blocks:** hold `start` high, chaining `h_out` into `h_in` for the two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq". Required:
  - final `h_out` = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1;
  - `done` pulses 66 cycles apart.
- **Ignore and reset mid-run:**
  - Pulse `start` at round t=20 with a different `h_in`: no effect, result unchanged.
  - Separate run: assert `reset` at t=40. Required: IDLE next cycle, no `done`, `h_out`=0; a fresh "abc" run then passes.
